// File: rtl/udma_sdio_pkg.sv
// Shared types and register map for the SDIO uDMA register interface with command queue.
package udma_sdio_pkg;

  localparam int unsigned RSP_W = 128;

  typedef struct packed {
    logic [5:0]  op;
    logic [2:0]  rsp_type;
    logic [31:0] arg;
    logic        data_en;
    logic        rwn;
    logic        quad;
    logic [9:0]  block_size;
    logic [7:0]  block_num;
  } sdio_cmd_t;

  localparam logic [4:0] REG_RX_SADDR   = 5'h00;
  localparam logic [4:0] REG_RX_SIZE    = 5'h01;
  localparam logic [4:0] REG_RX_CFG     = 5'h02;
  localparam logic [4:0] REG_RX_INTCFG  = 5'h03;
  localparam logic [4:0] REG_TX_SADDR   = 5'h04;
  localparam logic [4:0] REG_TX_SIZE    = 5'h05;
  localparam logic [4:0] REG_TX_CFG     = 5'h06;
  localparam logic [4:0] REG_TX_INTCFG  = 5'h07;
  localparam logic [4:0] REG_CMD_OP     = 5'h08;
  localparam logic [4:0] REG_CMD_ARG    = 5'h09;
  localparam logic [4:0] REG_DATA_SETUP = 5'h0A;
  localparam logic [4:0] REG_START      = 5'h0B;
  localparam logic [4:0] REG_RSP0       = 5'h0C;
  localparam logic [4:0] REG_RSP1       = 5'h0D;
  localparam logic [4:0] REG_RSP2       = 5'h0E;
  localparam logic [4:0] REG_RSP3       = 5'h0F;
  localparam logic [4:0] REG_CLK_DIV    = 5'h10;
  localparam logic [4:0] REG_STATUS     = 5'h11;
  localparam logic [4:0] REG_CMDQ       = 5'h12;
  localparam logic [4:0] REG_IRQ_EN     = 5'h13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } sdio_state_e;

endpackage

// File: rtl/udma_sdio_cmd_fifo.sv
// Synchronous DEPTH-entry command FIFO; flush wins over push/pop, pushes into a full FIFO are dropped.
module udma_sdio_cmd_fifo
  import udma_sdio_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push_i,
  input  sdio_cmd_t                data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output sdio_cmd_t                head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  sdio_cmd_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full_c  = (count_o == CW'(DEPTH));
  assign empty_c = (count_o == '0);
  assign head_c  = mem[rd_ptr];
  assign push_ok = push_i & ~full_c & ~flush_i;
  assign pop_ok  = pop_i & ~empty_c & ~flush_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count_o <= count_o + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/udma_sdio_cmdq_reg_if.sv
// SDIO uDMA config registers with a command queue that issues commands back-to-back to the SDIO core.
module udma_sdio_cmdq_reg_if
  import udma_sdio_pkg::*;
#(
  parameter int unsigned L2_AWIDTH_NOAL = 12,
  parameter int unsigned TRANS_SIZE     = 16,
  parameter int unsigned CMDQ_DEPTH     = 4
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [31:0]               cfg_data_i,
  input  logic [4:0]                cfg_addr_i,
  input  logic                      cfg_valid_i,
  input  logic                      cfg_rwn_i,
  output logic [31:0]               cfg_data_o,
  output logic                      cfg_ready_o,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     cfg_rx_size_o,
  output logic                      cfg_rx_continuous_o,
  output logic                      cfg_rx_en_o,
  output logic                      cfg_rx_clr_o,
  input  logic                      cfg_rx_en_i,
  input  logic                      cfg_rx_pending_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_rx_bytes_left_i,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_tx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     cfg_tx_size_o,
  output logic                      cfg_tx_continuous_o,
  output logic                      cfg_tx_en_o,
  output logic                      cfg_tx_clr_o,
  input  logic                      cfg_tx_en_i,
  input  logic                      cfg_tx_pending_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_tx_curr_addr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_tx_bytes_left_i,
  output logic                      cfg_sdio_start_o,
  output logic [5:0]                cfg_cmd_op_o,
  output logic [31:0]               cfg_cmd_arg_o,
  output logic [2:0]                cfg_cmd_rsp_type_o,
  output logic                      cfg_data_en_o,
  output logic                      cfg_data_rwn_o,
  output logic                      cfg_data_quad_o,
  output logic [9:0]                cfg_data_block_size_o,
  output logic [7:0]                cfg_data_block_num_o,
  input  logic [RSP_W-1:0]          cfg_rsp_data_i,
  input  logic [15:0]               txrx_status_i,
  input  logic                      txrx_eot_i,
  input  logic                      txrx_err_i,
  output logic [7:0]                cfg_clk_div_data_o,
  output logic                      cfg_clk_div_valid_o,
  input  logic                      cfg_clk_div_ack_i,
  output logic                      irq_o
);

  localparam int unsigned CW = $clog2(CMDQ_DEPTH) + 1;

  sdio_state_e       state;
  sdio_cmd_t         stg;
  sdio_cmd_t         active;
  sdio_cmd_t         q_head;
  logic              q_full;
  logic              q_empty;
  logic [CW-1:0]     q_count;
  logic [RSP_W-1:0]  rsp;
  logic [15:0]       last_status;
  logic              halt_on_err;
  logic [3:0]        irq_en;
  logic [3:0]        sticky;
  logic [3:0]        sticky_set;
  logic [3:0]        sticky_w1c;
  logic [3:0]        sticky_nxt;
  logic              wr_en;
  logic              sw_push;
  logic              sw_flush;
  logic              push_ok;
  logic              cmpl;
  logic              halt_flush;
  logic              fifo_flush;

  assign cfg_ready_o = 1'b1;
  assign wr_en       = cfg_valid_i & ~cfg_rwn_i;
  assign sw_flush    = wr_en & (cfg_addr_i == REG_START) & cfg_data_i[1];
  assign sw_push     = wr_en & (cfg_addr_i == REG_START) & cfg_data_i[0] & ~cfg_data_i[1];
  assign cmpl        = (state == ST_WAIT) & (txrx_eot_i | txrx_err_i);
  assign halt_flush  = cmpl & txrx_err_i & halt_on_err;
  assign fifo_flush  = sw_flush | halt_flush;
  assign push_ok     = sw_push & ~q_full & ~fifo_flush;

  // Sticky order {done, ovf, err, eot}; a set in the same cycle as a W1C wins.
  assign sticky_set = {cmpl & (halt_flush | sw_flush | (q_empty & ~push_ok)),
                       sw_push & q_full,
                       cmpl & txrx_err_i,
                       cmpl & txrx_eot_i};
  assign sticky_w1c = (wr_en && cfg_addr_i == REG_STATUS) ? cfg_data_i[3:0] : 4'h0;
  assign sticky_nxt = (sticky & ~sticky_w1c) | sticky_set;

  udma_sdio_cmd_fifo #(
    .DEPTH (CMDQ_DEPTH)
  ) i_cmd_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (sw_push),
    .data_i  (stg),
    .pop_i   (state == ST_ISSUE),
    .flush_i (fifo_flush),
    .head_c  (q_head),
    .full_c  (q_full),
    .empty_c (q_empty),
    .count_o (q_count)
  );

  // Issue sequencer; the active command is loaded on entry to ISSUE so it is valid with the start pulse.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state            <= ST_IDLE;
      cfg_sdio_start_o <= 1'b0;
      active           <= '0;
    end else begin
      cfg_sdio_start_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_flush && (!q_empty || push_ok)) begin
            active           <= q_empty ? stg : q_head;
            cfg_sdio_start_o <= 1'b1;
            state            <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT:  if (cmpl) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign cfg_cmd_op_o          = active.op;
  assign cfg_cmd_arg_o         = active.arg;
  assign cfg_cmd_rsp_type_o    = active.rsp_type;
  assign cfg_data_en_o         = active.data_en;
  assign cfg_data_rwn_o        = active.rwn;
  assign cfg_data_quad_o       = active.quad;
  assign cfg_data_block_size_o = active.block_size;
  assign cfg_data_block_num_o  = active.block_num;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cfg_rx_startaddr_o  <= '0;
      cfg_rx_size_o       <= '0;
      cfg_rx_continuous_o <= 1'b0;
      cfg_rx_en_o         <= 1'b0;
      cfg_rx_clr_o        <= 1'b0;
      cfg_tx_startaddr_o  <= '0;
      cfg_tx_size_o       <= '0;
      cfg_tx_continuous_o <= 1'b0;
      cfg_tx_en_o         <= 1'b0;
      cfg_tx_clr_o        <= 1'b0;
      cfg_clk_div_data_o  <= '0;
      cfg_clk_div_valid_o <= 1'b0;
      stg                 <= '0;
      rsp                 <= '0;
      last_status         <= '0;
      halt_on_err         <= 1'b0;
      irq_en              <= '0;
      sticky              <= '0;
      irq_o               <= 1'b0;
    end else begin
      cfg_rx_en_o  <= 1'b0;
      cfg_rx_clr_o <= 1'b0;
      cfg_tx_en_o  <= 1'b0;
      cfg_tx_clr_o <= 1'b0;
      sticky       <= sticky_nxt;
      irq_o        <= |(sticky_nxt & irq_en);
      if (cmpl) begin
        rsp         <= cfg_rsp_data_i;
        last_status <= txrx_status_i;
      end
      if (cfg_clk_div_ack_i) cfg_clk_div_valid_o <= 1'b0;
      if (wr_en) begin
        case (cfg_addr_i)
          REG_RX_SADDR: cfg_rx_startaddr_o <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
          REG_RX_SIZE:  cfg_rx_size_o      <= cfg_data_i[TRANS_SIZE-1:0];
          REG_RX_CFG: begin
            cfg_rx_continuous_o <= cfg_data_i[0];
            cfg_rx_en_o         <= cfg_data_i[4];
            cfg_rx_clr_o        <= cfg_data_i[5];
          end
          REG_TX_SADDR: cfg_tx_startaddr_o <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
          REG_TX_SIZE:  cfg_tx_size_o      <= cfg_data_i[TRANS_SIZE-1:0];
          REG_TX_CFG: begin
            cfg_tx_continuous_o <= cfg_data_i[0];
            cfg_tx_en_o         <= cfg_data_i[4];
            cfg_tx_clr_o        <= cfg_data_i[5];
          end
          REG_CMD_OP: begin
            stg.op       <= cfg_data_i[13:8];
            stg.rsp_type <= cfg_data_i[2:0];
          end
          REG_CMD_ARG: stg.arg <= cfg_data_i;
          REG_DATA_SETUP: begin
            stg.data_en    <= cfg_data_i[0];
            stg.rwn        <= cfg_data_i[1];
            stg.quad       <= cfg_data_i[2];
            stg.block_num  <= cfg_data_i[15:8];
            stg.block_size <= cfg_data_i[25:16];
          end
          REG_CLK_DIV: begin
            cfg_clk_div_data_o <= cfg_data_i[7:0];
            if (cfg_data_i[8]) cfg_clk_div_valid_o <= 1'b1;
          end
          REG_CMDQ:   halt_on_err <= cfg_data_i[0];
          REG_IRQ_EN: irq_en      <= cfg_data_i[3:0];
          default: ;
        endcase
      end
    end
  end

  // Read mux, combinational from the address.
  always_comb begin
    cfg_data_o = '0;
    case (cfg_addr_i)
      REG_RX_SADDR:   cfg_data_o = 32'(cfg_rx_curr_addr_i);
      REG_RX_SIZE:    cfg_data_o = 32'(cfg_rx_bytes_left_i);
      REG_RX_CFG:     cfg_data_o = {26'h0, cfg_rx_pending_i, cfg_rx_en_i, 3'h0, cfg_rx_continuous_o};
      REG_TX_SADDR:   cfg_data_o = 32'(cfg_tx_curr_addr_i);
      REG_TX_SIZE:    cfg_data_o = 32'(cfg_tx_bytes_left_i);
      REG_TX_CFG:     cfg_data_o = {26'h0, cfg_tx_pending_i, cfg_tx_en_i, 3'h0, cfg_tx_continuous_o};
      REG_CMD_OP:     cfg_data_o = {18'h0, stg.op, 5'h0, stg.rsp_type};
      REG_CMD_ARG:    cfg_data_o = stg.arg;
      REG_DATA_SETUP: cfg_data_o = {6'h0, stg.block_size, stg.block_num, 5'h0, stg.quad, stg.rwn, stg.data_en};
      REG_RSP0:       cfg_data_o = rsp[31:0];
      REG_RSP1:       cfg_data_o = rsp[63:32];
      REG_RSP2:       cfg_data_o = rsp[95:64];
      REG_RSP3:       cfg_data_o = rsp[127:96];
      REG_CLK_DIV:    cfg_data_o = {23'h0, cfg_clk_div_valid_o, cfg_clk_div_data_o};
      REG_STATUS:     cfg_data_o = {last_status, 12'h0, sticky};
      REG_CMDQ:       cfg_data_o = {16'h0, state != ST_IDLE, q_full, q_empty, 1'b0, halt_on_err, 11'(q_count)};
      REG_IRQ_EN:     cfg_data_o = {28'h0, irq_en};
      default:        cfg_data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_udma_sdio_cmdq_reg_if.sv
// Scoreboard bench: queued commands are expected at each start pulse, plus register/status checks.
module tb_udma_sdio_cmdq_reg_if;
  import udma_sdio_pkg::*;

  localparam int unsigned AW    = 12;
  localparam int unsigned TS    = 16;
  localparam int unsigned DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic [31:0]   cfg_data_i = '0;
  logic [4:0]    cfg_addr_i = '0;
  logic          cfg_valid_i = 1'b0;
  logic          cfg_rwn_i = 1'b1;
  logic [31:0]   cfg_data_o;
  logic          cfg_ready_o;
  logic [AW-1:0] cfg_rx_startaddr_o, cfg_tx_startaddr_o;
  logic [TS-1:0] cfg_rx_size_o, cfg_tx_size_o;
  logic          cfg_rx_continuous_o, cfg_rx_en_o, cfg_rx_clr_o;
  logic          cfg_tx_continuous_o, cfg_tx_en_o, cfg_tx_clr_o;
  logic          cfg_sdio_start_o;
  logic [5:0]    cfg_cmd_op_o;
  logic [31:0]   cfg_cmd_arg_o;
  logic [2:0]    cfg_cmd_rsp_type_o;
  logic          cfg_data_en_o, cfg_data_rwn_o, cfg_data_quad_o;
  logic [9:0]    cfg_data_block_size_o;
  logic [7:0]    cfg_data_block_num_o;
  logic [127:0]  cfg_rsp_data_i = '0;
  logic [15:0]   txrx_status_i = '0;
  logic          txrx_eot_i = 1'b0;
  logic          txrx_err_i = 1'b0;
  logic [7:0]    cfg_clk_div_data_o;
  logic          cfg_clk_div_valid_o;
  logic          cfg_clk_div_ack_i = 1'b0;
  logic          irq_o;

  int            n_vec = 0;
  int            n_err = 0;
  int            start_cnt = 0;
  sdio_cmd_t     exp_q[$];
  sdio_cmd_t     last_started = '0;

  always #5 clk_i = ~clk_i;

  udma_sdio_cmdq_reg_if #(
    .L2_AWIDTH_NOAL (AW),
    .TRANS_SIZE     (TS),
    .CMDQ_DEPTH     (DEPTH)
  ) dut (
    .clk_i                 (clk_i),
    .rstn_i                (rstn_i),
    .cfg_data_i            (cfg_data_i),
    .cfg_addr_i            (cfg_addr_i),
    .cfg_valid_i           (cfg_valid_i),
    .cfg_rwn_i             (cfg_rwn_i),
    .cfg_data_o            (cfg_data_o),
    .cfg_ready_o           (cfg_ready_o),
    .cfg_rx_startaddr_o    (cfg_rx_startaddr_o),
    .cfg_rx_size_o         (cfg_rx_size_o),
    .cfg_rx_continuous_o   (cfg_rx_continuous_o),
    .cfg_rx_en_o           (cfg_rx_en_o),
    .cfg_rx_clr_o          (cfg_rx_clr_o),
    .cfg_rx_en_i           (1'b0),
    .cfg_rx_pending_i      (1'b0),
    .cfg_rx_curr_addr_i    ('0),
    .cfg_rx_bytes_left_i   ('0),
    .cfg_tx_startaddr_o    (cfg_tx_startaddr_o),
    .cfg_tx_size_o         (cfg_tx_size_o),
    .cfg_tx_continuous_o   (cfg_tx_continuous_o),
    .cfg_tx_en_o           (cfg_tx_en_o),
    .cfg_tx_clr_o          (cfg_tx_clr_o),
    .cfg_tx_en_i           (1'b0),
    .cfg_tx_pending_i      (1'b0),
    .cfg_tx_curr_addr_i    ('0),
    .cfg_tx_bytes_left_i   ('0),
    .cfg_sdio_start_o      (cfg_sdio_start_o),
    .cfg_cmd_op_o          (cfg_cmd_op_o),
    .cfg_cmd_arg_o         (cfg_cmd_arg_o),
    .cfg_cmd_rsp_type_o    (cfg_cmd_rsp_type_o),
    .cfg_data_en_o         (cfg_data_en_o),
    .cfg_data_rwn_o        (cfg_data_rwn_o),
    .cfg_data_quad_o       (cfg_data_quad_o),
    .cfg_data_block_size_o (cfg_data_block_size_o),
    .cfg_data_block_num_o  (cfg_data_block_num_o),
    .cfg_rsp_data_i        (cfg_rsp_data_i),
    .txrx_status_i         (txrx_status_i),
    .txrx_eot_i            (txrx_eot_i),
    .txrx_err_i            (txrx_err_i),
    .cfg_clk_div_data_o    (cfg_clk_div_data_o),
    .cfg_clk_div_valid_o   (cfg_clk_div_valid_o),
    .cfg_clk_div_ack_i     (cfg_clk_div_ack_i),
    .irq_o                 (irq_o)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic sdio_cmd_t active_cmd();
    return {cfg_cmd_op_o, cfg_cmd_rsp_type_o, cfg_cmd_arg_o, cfg_data_en_o,
            cfg_data_rwn_o, cfg_data_quad_o, cfg_data_block_size_o, cfg_data_block_num_o};
  endfunction

  function automatic sdio_cmd_t mk_cmd(input logic [5:0] op);
    sdio_cmd_t c;
    c.op         = op;
    c.rsp_type   = 3'($urandom_range(0, 7));
    c.arg        = $urandom;
    c.data_en    = 1'($urandom);
    c.rwn        = 1'($urandom);
    c.quad       = 1'($urandom);
    c.block_size = 10'($urandom);
    c.block_num  = 8'($urandom);
    return c;
  endfunction

  task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk_i); #1;
    cfg_addr_i = a; cfg_data_i = d; cfg_rwn_i = 1'b0; cfg_valid_i = 1'b1;
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b0; cfg_rwn_i = 1'b1;
  endtask

  task automatic cfg_rd(input logic [4:0] a, output logic [31:0] d);
    @(posedge clk_i); #1;
    cfg_addr_i = a; cfg_rwn_i = 1'b1; cfg_valid_i = 1'b1;
    @(negedge clk_i);
    d = cfg_data_o;
    cfg_valid_i = 1'b0;
  endtask

  task automatic push_cmd(input sdio_cmd_t c, input bit accept);
    cfg_wr(REG_CMD_OP, {18'h0, c.op, 5'h0, c.rsp_type});
    cfg_wr(REG_CMD_ARG, c.arg);
    cfg_wr(REG_DATA_SETUP, {6'h0, c.block_size, c.block_num, 5'h0, c.quad, c.rwn, c.data_en});
    if (accept) exp_q.push_back(c);
    cfg_wr(REG_START, 32'h1);
  endtask

  task automatic wait_starts(input int n);
    int t = 0;
    while (start_cnt < n && t < 300) begin
      @(negedge clk_i);
      t++;
    end
    chk("start_wait", 64'(start_cnt >= n), 64'd1);
  endtask

  task automatic pulse_done(input bit eot, input bit err, input logic [15:0] st, input logic [127:0] r);
    @(posedge clk_i); #1;
    txrx_eot_i = eot; txrx_err_i = err; txrx_status_i = st; cfg_rsp_data_i = r;
    chk("active_stable", 64'(active_cmd()), 64'(last_started));
    @(posedge clk_i); #1;
    txrx_eot_i = 1'b0; txrx_err_i = 1'b0;
  endtask

  // Start-pulse monitor: each pulse must present the oldest accepted command.
  initial begin
    sdio_cmd_t e;
    forever begin
      @(negedge clk_i);
      if (rstn_i && cfg_sdio_start_o) begin
        start_cnt++;
        last_started = active_cmd();
        if (exp_q.size() == 0) chk("unexpected_start", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("issued_cmd", 64'(active_cmd()), 64'(e));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0]  d;
    logic [127:0] r;
    logic [15:0]  st;
    sdio_cmd_t    c;
    int           base;
    logic [5:0]   ops [3];
    ops[0] = 6'd17; ops[1] = 6'd18; ops[2] = 6'd24;

    repeat (3) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    chk("rst_irq", 64'(irq_o), 64'd0);
    chk("rst_start", 64'(cfg_sdio_start_o), 64'd0);
    chk("rst_clkdiv_valid", 64'(cfg_clk_div_valid_o), 64'd0);
    cfg_rd(REG_STATUS, d); chk("rst_status", 64'(d), 64'h0);
    cfg_rd(REG_CMDQ, d);   chk("rst_cmdq", 64'(d), 64'h0000_2000);
    cfg_rd(REG_RSP0, d);   chk("rst_rsp0", 64'(d), 64'h0);

    // channel registers
    cfg_wr(REG_RX_SADDR, 32'h0000_0123);
    chk("rx_saddr", 64'(cfg_rx_startaddr_o), 64'h123);
    cfg_wr(REG_TX_CFG, 32'h31);
    chk("tx_cfg_pulse", 64'({cfg_tx_en_o, cfg_tx_clr_o, cfg_tx_continuous_o}), 64'h7);
    @(posedge clk_i); #1;
    chk("tx_cfg_pulse_end", 64'({cfg_tx_en_o, cfg_tx_clr_o, cfg_tx_continuous_o}), 64'h1);

    // three commands back-to-back, eot 5 cycles after each start
    base = start_cnt;
    for (int i = 0; i < 3; i++) begin
      push_cmd(mk_cmd(ops[i]), 1'b1);
      if (i == 0) chk("start_latency", 64'(cfg_sdio_start_o), 64'd1);
    end
    for (int k = 1; k <= 3; k++) begin
      wait_starts(base + k);
      repeat (5) @(posedge clk_i);
      r = {$urandom, $urandom, $urandom, $urandom};
      st = 16'(16'h1000 + k);
      pulse_done(1'b1, 1'b0, st, r);
    end
    repeat (4) @(posedge clk_i);
    #1 cfg_rsp_data_i = ~r;
    chk("seq_starts", 64'(start_cnt), 64'(base + 3));
    cfg_rd(REG_STATUS, d); chk("seq_status", 64'(d), 64'({st, 12'h0, 4'b1001}));
    cfg_rd(REG_CMDQ, d);   chk("seq_cmdq", 64'(d), 64'h0000_2000);
    cfg_rd(REG_RSP0, d);   chk("rsp0", 64'(d), 64'(r[31:0]));
    cfg_rd(REG_RSP1, d);   chk("rsp1", 64'(d), 64'(r[63:32]));
    cfg_rd(REG_RSP2, d);   chk("rsp2", 64'(d), 64'(r[95:64]));
    cfg_rd(REG_RSP3, d);   chk("rsp3", 64'(d), 64'(r[127:96]));

    // overflow: one in flight stalled, then five pushes into a 4-deep queue
    cfg_wr(REG_STATUS, 32'hF);
    cfg_wr(REG_IRQ_EN, 32'h4);
    base = start_cnt;
    push_cmd(mk_cmd(6'd1), 1'b1);
    wait_starts(base + 1);
    for (int i = 0; i < 4; i++) push_cmd(mk_cmd(6'(2 + i)), 1'b1);
    chk("pre_ovf_irq", 64'(irq_o), 64'd0);
    push_cmd(mk_cmd(6'd9), 1'b0);
    chk("ovf_irq", 64'(irq_o), 64'd1);
    cfg_rd(REG_CMDQ, d);   chk("ovf_cmdq", 64'(d), 64'h0000_C004);
    cfg_rd(REG_STATUS, d); chk("ovf_sticky", 64'(d[3:0]), 64'h4);
    for (int k = 1; k <= 5; k++) begin
      wait_starts(base + k);
      pulse_done(1'b1, 1'b0, 16'h0, 128'(k));
    end
    repeat (10) @(posedge clk_i);
    chk("ovf_starts", 64'(start_cnt), 64'(base + 5));
    chk("ovf_sb_empty", 64'(exp_q.size()), 64'd0);

    // halt on error with two commands queued behind the failing one
    cfg_wr(REG_IRQ_EN, 32'h0);
    cfg_wr(REG_STATUS, 32'hF);
    cfg_wr(REG_CMDQ, 32'h1);
    base = start_cnt;
    for (int i = 0; i < 3; i++) push_cmd(mk_cmd(6'(30 + i)), 1'b1);
    wait_starts(base + 1);
    pulse_done(1'b1, 1'b1, 16'hBEEF, 128'h5);
    exp_q.delete();
    repeat (10) @(posedge clk_i);
    chk("halt_starts", 64'(start_cnt), 64'(base + 1));
    cfg_rd(REG_STATUS, d); chk("halt_status", 64'(d), 64'hBEEF_000B);
    cfg_rd(REG_CMDQ, d);   chk("halt_cmdq", 64'(d), 64'h0000_2800);
    cfg_wr(REG_CMDQ, 32'h0);
    cfg_wr(REG_STATUS, 32'hF);

    // flush while waiting, with a simultaneous push that must lose
    base = start_cnt;
    for (int i = 0; i < 3; i++) push_cmd(mk_cmd(6'(40 + i)), 1'b1);
    wait_starts(base + 1);
    cfg_rd(REG_CMDQ, d);   chk("pre_flush_cmdq", 64'(d), 64'h0000_8002);
    cfg_wr(REG_START, 32'h3);
    exp_q.delete();
    cfg_rd(REG_CMDQ, d);   chk("flush_cmdq", 64'(d), 64'h0000_A000);
    pulse_done(1'b1, 1'b0, 16'h00F1, 128'h7);
    repeat (10) @(posedge clk_i);
    chk("flush_starts", 64'(start_cnt), 64'(base + 1));
    cfg_rd(REG_STATUS, d); chk("flush_status", 64'(d), 64'h00F1_0009);

    // W1C of eot in the same cycle as a new eot
    cfg_wr(REG_IRQ_EN, 32'h1);
    base = start_cnt;
    push_cmd(mk_cmd(6'd50), 1'b1);
    wait_starts(base + 1);
    @(posedge clk_i); #1;
    cfg_addr_i = REG_STATUS; cfg_data_i = 32'h1; cfg_rwn_i = 1'b0; cfg_valid_i = 1'b1;
    txrx_eot_i = 1'b1;
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b0; cfg_rwn_i = 1'b1; txrx_eot_i = 1'b0;
    chk("w1c_race_irq", 64'(irq_o), 64'd1);
    cfg_rd(REG_STATUS, d); chk("w1c_race_eot", 64'(d[3:0]), 64'h9);
    cfg_wr(REG_STATUS, 32'hF);
    chk("w1c_irq_clear", 64'(irq_o), 64'd0);
    cfg_rd(REG_STATUS, d); chk("w1c_clear", 64'(d[3:0]), 64'h0);

    // clock divider handshake
    cfg_wr(REG_CLK_DIV, 32'h105);
    chk("clkdiv_data", 64'(cfg_clk_div_data_o), 64'h05);
    chk("clkdiv_valid_c1", 64'(cfg_clk_div_valid_o), 64'd1);
    for (int i = 2; i <= 4; i++) begin
      @(posedge clk_i); #1;
      chk("clkdiv_valid_hold", 64'(cfg_clk_div_valid_o), 64'd1);
    end
    cfg_clk_div_ack_i = 1'b1;
    @(posedge clk_i); #1;
    cfg_clk_div_ack_i = 1'b0;
    chk("clkdiv_valid_ack", 64'(cfg_clk_div_valid_o), 64'd0);
    cfg_wr(REG_CLK_DIV, 32'h133);
    cfg_wr(REG_CLK_DIV, 32'h077);
    chk("clkdiv_update_data", 64'(cfg_clk_div_data_o), 64'h77);
    chk("clkdiv_update_valid", 64'(cfg_clk_div_valid_o), 64'd1);
    @(posedge clk_i); #1;
    cfg_clk_div_ack_i = 1'b1;
    @(posedge clk_i); #1;
    cfg_clk_div_ack_i = 1'b0;
    chk("clkdiv_update_ack", 64'(cfg_clk_div_valid_o), 64'd0);

    repeat (5) @(posedge clk_i);
    chk("final_sb_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
